fetch_queue: RTL and testbench
==============================

# fetch_queue

Dual-wide instruction fetch queue between the dual-output instruction cache and the decode/issue stage. Each cycle it accepts up to one instruction pair (instruction plus PC for each slot) and presents the two oldest entries to decode. Decode pops 0, 1 or 2 entries per cycle. `in_ready` back-pressures the fetch PC, and `flush` discards all contents on a branch redirect.

## Interface
- `DEPTH`, default 8: number of entries. Must be a power of two and at least 4.
- `WIDTH`, default 32: instruction and PC width.
- `clk`, input, 1: the single clock. All state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-low. Low clears all state immediately.
- `in_valid`, input, 1: the cache is offering a pair this cycle.
- `in_instr_1`, `in_instr_2`, input, WIDTH: instructions; slot 1 is older.
- `in_pc_1`, `in_pc_2`, input, WIDTH: PCs of the two slots. In normal fetch `in_pc_2` = `in_pc_1` + 4; the queue does not check this.
- `in_ready`, output, 1: at least 2 entries are free.
- `flush`, input, 1: discard all entries and any same-cycle enqueue.
- `deq_count`, input, 2: entries decode takes this cycle (0, 1 or 2). The value 3 is treated as 2.
- `out_valid_1`, `out_valid_2`, output, 1: head entry and head+1 entry are valid.
- `out_instr_1`, `out_instr_2`, output, WIDTH: instructions of the head and head+1 entries.
- `out_pc_1`, `out_pc_2`, output, WIDTH: PCs of the head and head+1 entries.
- `count`, output, log2(DEPTH)+1: current occupancy.

## Operation
- **Storage:** DEPTH entries of {instr, pc}.
  - Pointers `head` and `tail` are log2(DEPTH) bits wide and wrap modulo DEPTH.
  - The storage array is not reset.
- **Ready:** `in_ready` = (`count` <= DEPTH-2). It is combinational from registered state only and never depends on `deq_count`.
- **Enqueue** (`enq`) = `in_valid` & `in_ready` & !`flush`.
  - Slot 1 is written at `tail` and slot 2 at `tail`+1.
  - `tail` advances by 2.
  - A pair is always accepted or rejected as a unit.
  - `in_valid` while `in_ready` is low is ignored; fetch must hold its PC.
- **Dequeue** (`deq`) = min(`deq_count` clamped to 2, `count`) when `flush` is low; `head` advances by `deq`. Over-request is clamped, never an underflow.
- **Occupancy update:** `count` next = `count` + 2·`enq` − `deq`. Enqueue and dequeue in the same cycle are both honoured.
- **Flush:** `head`, `tail` and `count` go to 0 next cycle. Flush overrides enqueue and dequeue.
- **Outputs:** show-ahead, combinational from `head`.
  - `out_valid_1` = (`count` >= 1).
  - `out_valid_2` = (`count` >= 2).
  - `out_instr_*` and `out_pc_*` are 0 whenever their valid is low.
- **Reset:** on `reset` low, asynchronously:
  - `head`, `tail` and `count` = 0.
  - `out_valid_1` and `out_valid_2` = 0; `out_instr_*` and `out_pc_*` = 0.
  - `in_ready` = 1.

  This applies mid-operation too: all contents are lost.

## Timing
- Enqueue-to-output latency is 1 cycle. There is no bypass, so an empty queue shows a new pair on the cycle after acceptance.
- Dequeue takes effect at the edge. The next entries appear on the outputs in the following cycle.
- Flush asserted in cycle N gives `count` = 0 and both valids low from cycle N+1. Enqueue is possible again in cycle N+1.
- **Full boundary:**
  - At `count` = DEPTH-1, `in_ready` is low even if decode pops that cycle. This conservative rule avoids a combinational path through `deq_count`.
  - At `count` = DEPTH the queue is full and both valids are high.
- **Wrap-around:** program order is preserved across pointer wrap. A pair may straddle index DEPTH-1 → 0.

## Structure
- Package `fetch_pkg`:
  - `fetch_entry_t`, a packed struct {logic [31:0] instr; logic [31:0] pc}.
  - `FQ_DEPTH_DEFAULT` = 8.
  - `DEQ_MAX` = 2.
- Single module; no sub-module is needed. Pointer and count logic and the storage array live inline.
- The cache and PC generator connect directly: `in_ready` gates PC advance by 8.

## Test plan
- **Reset:** drive `reset` = 0 mid-run with `count` = 5.
  - Immediately: `count` = 0, both valids = 0, outputs 0, `in_ready` = 1.
  - After release, contents are gone.
- **Single pair:** enqueue {0x00000013 @ pc 0x0, 0x00100093 @ pc 0x4} into an empty queue.
  - Next cycle: `out_valid_1` = `out_valid_2` = 1, `out_pc_1` = 0x0, `out_pc_2` = 0x4, `count` = 2.
- **Fill/back-pressure:** 4 enqueues with `deq_count` = 0 (DEPTH = 8).
  - Result: `count` = 8, `in_ready` = 0.
  - A 5th pair held on `in_valid` is not written; `count` stays 8.
- **Simultaneous enqueue and dequeue:** at `count` = 6, enqueue a pair and pop 1.
  - Result: `count` = 7, `in_ready` = 0, and `out_pc_1` advances by 4.
  - Continue popping 2 per cycle and verify PC order is unbroken across the wrap at index 7 → 0.
- **Over-dequeue:** at `count` = 1, set `deq_count` = 2 (and also try 3).
  - Result: `count` = 0, no underflow, valids 0.
- **Flush priority:** at `count` = 4, assert `flush` together with `in_valid` = 1 and `deq_count` = 2.
  - Next cycle: `count` = 0, valids 0.
  - An enqueue in the following cycle appears as the new head.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the dual-wide fetch queue.
// Imported by the queue and by anything that packs fetch entries.
package fetch_pkg;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    localparam int FQ_DEPTH_DEFAULT = 8;
    localparam int DEQ_MAX          = 2;

endpackage

// File: rtl/fetch_queue.sv
// Dual-wide show-ahead fetch queue between icache and decode.
// Accepts one instruction pair per cycle and presents the two oldest entries.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH_DEFAULT,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_instr_1,
    input  logic [WIDTH-1:0]           in_instr_2,
    input  logic [WIDTH-1:0]           in_pc_1,
    input  logic [WIDTH-1:0]           in_pc_2,
    output logic                       in_ready,
    input  logic                       flush,
    input  logic [1:0]                 deq_count,
    output logic                       out_valid_1,
    output logic                       out_valid_2,
    output logic [WIDTH-1:0]           out_instr_1,
    output logic [WIDTH-1:0]           out_instr_2,
    output logic [WIDTH-1:0]           out_pc_1,
    output logic [WIDTH-1:0]           out_pc_2,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_instr [DEPTH];
    logic [WIDTH-1:0] mem_pc    [DEPTH];

    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW-1:0] head_nx1;
    logic [AW-1:0] tail_nx1;
    logic          enq;
    logic [1:0]    req;
    logic [CW-1:0] deq;
    logic [CW-1:0] count_nxt;

    // Ready looks only at registered occupancy, never at deq_count.
    assign in_ready = (count <= CW'(DEPTH - 2));
    assign enq      = in_valid & in_ready & ~flush;
    assign head_nx1 = head + AW'(1);
    assign tail_nx1 = tail + AW'(1);

    always_comb begin
        req       = (deq_count > 2'(DEQ_MAX)) ? 2'(DEQ_MAX) : deq_count;
        deq       = (CW'(req) > count) ? count : CW'(req);
        count_nxt = count - deq;
        if (enq) begin
            count_nxt = count_nxt + CW'(2);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + AW'(deq);
            count <= count_nxt;
            if (enq) begin
                tail <= tail + AW'(2);
            end
        end
    end

    // Storage carries no reset; validity comes from count alone.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_instr[tail]     <= in_instr_1;
            mem_pc[tail]        <= in_pc_1;
            mem_instr[tail_nx1] <= in_instr_2;
            mem_pc[tail_nx1]    <= in_pc_2;
        end
    end

    always_comb begin
        out_valid_1 = (count >= CW'(1));
        out_valid_2 = (count >= CW'(2));
        out_instr_1 = '0;
        out_pc_1    = '0;
        out_instr_2 = '0;
        out_pc_2    = '0;
        if (out_valid_1) begin
            out_instr_1 = mem_instr[head];
            out_pc_1    = mem_pc[head];
        end
        if (out_valid_2) begin
            out_instr_2 = mem_instr[head_nx1];
            out_pc_2    = mem_pc[head_nx1];
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed testbench for fetch_queue (DEPTH 8, WIDTH 32).
// Each scenario task drives stimulus and checks expected values inline.
module tb_fetch_queue;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_instr_1;
    logic [31:0] in_instr_2;
    logic [31:0] in_pc_1;
    logic [31:0] in_pc_2;
    logic        in_ready;
    logic        flush;
    logic [1:0]  deq_count;
    logic        out_valid_1;
    logic        out_valid_2;
    logic [31:0] out_instr_1;
    logic [31:0] out_instr_2;
    logic [31:0] out_pc_1;
    logic [31:0] out_pc_2;
    logic [3:0]  count;

    int checks;
    int errors;

    fetch_queue #(.DEPTH(8), .WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_instr_1  (in_instr_1),
        .in_instr_2  (in_instr_2),
        .in_pc_1     (in_pc_1),
        .in_pc_2     (in_pc_2),
        .in_ready    (in_ready),
        .flush       (flush),
        .deq_count   (deq_count),
        .out_valid_1 (out_valid_1),
        .out_valid_2 (out_valid_2),
        .out_instr_1 (out_instr_1),
        .out_instr_2 (out_instr_2),
        .out_pc_1    (out_pc_1),
        .out_pc_2    (out_pc_2),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        in_valid  = 1'b0;
        flush     = 1'b0;
        deq_count = 2'd0;
    endtask

    task automatic drive_pair(input logic [31:0] pc);
        in_valid   = 1'b1;
        in_pc_1    = pc;
        in_pc_2    = pc + 32'd4;
        in_instr_1 = pc + 32'h1000_0000;
        in_instr_2 = pc + 32'h1000_0004;
    endtask

    task automatic test_reset_state;
        #1;
        checks++;
        if (count !== 4'd0) begin
            errors++;
            $display("FAIL rst_count got %0d exp 0", count);
        end
        checks++;
        if (out_valid_1 !== 1'b0 || out_valid_2 !== 1'b0) begin
            errors++;
            $display("FAIL rst_valid got %b%b exp 00", out_valid_1, out_valid_2);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_ready got %b exp 1", in_ready);
        end
        checks++;
        if (out_pc_1 !== 32'h0 || out_instr_1 !== 32'h0) begin
            errors++;
            $display("FAIL rst_out got %h/%h exp 0/0", out_pc_1, out_instr_1);
        end
    endtask

    task automatic test_single_pair;
        in_valid   = 1'b1;
        in_instr_1 = 32'h0000_0013;
        in_pc_1    = 32'h0;
        in_instr_2 = 32'h0010_0093;
        in_pc_2    = 32'h4;
        tick();
        idle();
        checks++;
        if (out_valid_1 !== 1'b1 || out_valid_2 !== 1'b1) begin
            errors++;
            $display("FAIL sp_valid got %b%b exp 11", out_valid_1, out_valid_2);
        end
        checks++;
        if (out_pc_1 !== 32'h0 || out_pc_2 !== 32'h4) begin
            errors++;
            $display("FAIL sp_pc got %h/%h exp 0/4", out_pc_1, out_pc_2);
        end
        checks++;
        if (out_instr_1 !== 32'h0000_0013 || out_instr_2 !== 32'h0010_0093) begin
            errors++;
            $display("FAIL sp_instr got %h/%h exp 00000013/00100093", out_instr_1, out_instr_2);
        end
        checks++;
        if (count !== 4'd2) begin
            errors++;
            $display("FAIL sp_count got %0d exp 2", count);
        end
        deq_count = 2'd2;
        tick();
        idle();
        checks++;
        if (count !== 4'd0 || out_valid_1 !== 1'b0 || out_pc_1 !== 32'h0) begin
            errors++;
            $display("FAIL sp_drain got cnt %0d v %b pc %h exp 0 0 0", count, out_valid_1, out_pc_1);
        end
    endtask

    task automatic test_fill;
        logic [31:0] pc;
        for (int i = 0; i < 4; i++) begin
            pc = 32'h100 + 32'(i * 8);
            drive_pair(pc);
            tick();
        end
        idle();
        checks++;
        if (count !== 4'd8 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_full got cnt %0d rdy %b exp 8 0", count, in_ready);
        end
        checks++;
        if (out_valid_1 !== 1'b1 || out_valid_2 !== 1'b1) begin
            errors++;
            $display("FAIL fill_valid got %b%b exp 11", out_valid_1, out_valid_2);
        end
        drive_pair(32'h200);
        tick();
        idle();
        checks++;
        if (count !== 4'd8) begin
            errors++;
            $display("FAIL fill_hold got %0d exp 8", count);
        end
        for (int i = 0; i < 4; i++) begin
            pc = 32'h100 + 32'(i * 8);
            checks++;
            if (out_pc_1 !== pc || out_pc_2 !== pc + 32'd4) begin
                errors++;
                $display("FAIL fill_order[%0d] got %h/%h exp %h/%h", i, out_pc_1, out_pc_2, pc, pc + 32'd4);
            end
            deq_count = 2'd2;
            tick();
            idle();
        end
        checks++;
        if (count !== 4'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL fill_empty got cnt %0d rdy %b exp 0 1", count, in_ready);
        end
    endtask

    task automatic test_simul_and_wrap;
        logic [31:0] pc;
        for (int i = 0; i < 3; i++) begin
            drive_pair(32'h300 + 32'(i * 8));
            tick();
        end
        idle();
        checks++;
        if (count !== 4'd6 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL sim_pre got cnt %0d rdy %b exp 6 1", count, in_ready);
        end
        drive_pair(32'h318);
        deq_count = 2'd1;
        tick();
        idle();
        checks++;
        if (count !== 4'd7 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL sim_cnt got cnt %0d rdy %b exp 7 0", count, in_ready);
        end
        checks++;
        if (out_pc_1 !== 32'h304) begin
            errors++;
            $display("FAIL sim_head got %h exp 00000304", out_pc_1);
        end
        // Pop across the index 7 -> 0 boundary.
        drive_pair(32'h900);
        deq_count = 2'd1;
        tick();
        idle();
        checks++;
        if (count !== 4'd6 || out_pc_1 !== 32'h308) begin
            errors++;
            $display("FAIL sim_nordy got cnt %0d pc %h exp 6 308", count, out_pc_1);
        end
        pc = 32'h308;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_pc_1 !== pc || out_pc_2 !== pc + 32'd4) begin
                errors++;
                $display("FAIL wrap_order[%0d] got %h/%h exp %h/%h", i, out_pc_1, out_pc_2, pc, pc + 32'd4);
            end
            checks++;
            if (out_instr_1 !== pc + 32'h1000_0000) begin
                errors++;
                $display("FAIL wrap_instr[%0d] got %h exp %h", i, out_instr_1, pc + 32'h1000_0000);
            end
            deq_count = 2'd2;
            tick();
            idle();
            pc = pc + 32'd8;
        end
        checks++;
        if (count !== 4'd0 || out_valid_1 !== 1'b0) begin
            errors++;
            $display("FAIL wrap_end got cnt %0d v %b exp 0 0", count, out_valid_1);
        end
    endtask

    task automatic test_over_dequeue;
        drive_pair(32'h380);
        tick();
        idle();
        deq_count = 2'd1;
        tick();
        idle();
        checks++;
        if (count !== 4'd1 || out_valid_2 !== 1'b0 || out_pc_1 !== 32'h384) begin
            errors++;
            $display("FAIL ovr_pre got cnt %0d v2 %b pc %h exp 1 0 384", count, out_valid_2, out_pc_1);
        end
        deq_count = 2'd3;
        tick();
        idle();
        checks++;
        if (count !== 4'd0 || out_valid_1 !== 1'b0 || out_pc_1 !== 32'h0) begin
            errors++;
            $display("FAIL ovr_deq3 got cnt %0d v %b pc %h exp 0 0 0", count, out_valid_1, out_pc_1);
        end
        drive_pair(32'h3c0);
        tick();
        idle();
        deq_count = 2'd1;
        tick();
        deq_count = 2'd2;
        tick();
        idle();
        checks++;
        if (count !== 4'd0 || out_valid_1 !== 1'b0 || out_valid_2 !== 1'b0) begin
            errors++;
            $display("FAIL ovr_deq2 got cnt %0d v %b%b exp 0 00", count, out_valid_1, out_valid_2);
        end
        deq_count = 2'd2;
        tick();
        idle();
        checks++;
        if (count !== 4'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ovr_empty got cnt %0d rdy %b exp 0 1", count, in_ready);
        end
    endtask

    task automatic test_flush;
        drive_pair(32'h400);
        tick();
        drive_pair(32'h408);
        tick();
        idle();
        checks++;
        if (count !== 4'd4) begin
            errors++;
            $display("FAIL fl_pre got %0d exp 4", count);
        end
        drive_pair(32'h500);
        flush     = 1'b1;
        deq_count = 2'd2;
        tick();
        idle();
        checks++;
        if (count !== 4'd0 || out_valid_1 !== 1'b0 || out_valid_2 !== 1'b0) begin
            errors++;
            $display("FAIL fl_clear got cnt %0d v %b%b exp 0 00", count, out_valid_1, out_valid_2);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL fl_ready got %b exp 1", in_ready);
        end
        drive_pair(32'h600);
        tick();
        idle();
        checks++;
        if (count !== 4'd2 || out_pc_1 !== 32'h600 || out_pc_2 !== 32'h604) begin
            errors++;
            $display("FAIL fl_new got cnt %0d pc %h/%h exp 2 600/604", count, out_pc_1, out_pc_2);
        end
        checks++;
        if (out_instr_1 !== 32'h1000_0600) begin
            errors++;
            $display("FAIL fl_instr got %h exp 10000600", out_instr_1);
        end
        deq_count = 2'd2;
        tick();
        idle();
    endtask

    task automatic test_reset_midrun;
        for (int i = 0; i < 3; i++) begin
            drive_pair(32'h700 + 32'(i * 8));
            tick();
        end
        idle();
        deq_count = 2'd1;
        tick();
        idle();
        checks++;
        if (count !== 4'd5) begin
            errors++;
            $display("FAIL mr_pre got %0d exp 5", count);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (count !== 4'd0 || out_valid_1 !== 1'b0 || out_valid_2 !== 1'b0) begin
            errors++;
            $display("FAIL mr_async got cnt %0d v %b%b exp 0 00", count, out_valid_1, out_valid_2);
        end
        checks++;
        if (out_pc_1 !== 32'h0 || out_instr_1 !== 32'h0 || out_pc_2 !== 32'h0) begin
            errors++;
            $display("FAIL mr_out got %h/%h/%h exp 0/0/0", out_pc_1, out_instr_1, out_pc_2);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mr_ready got %b exp 1", in_ready);
        end
        #2;
        reset = 1'b1;
        tick();
        checks++;
        if (count !== 4'd0 || out_valid_1 !== 1'b0) begin
            errors++;
            $display("FAIL mr_gone got cnt %0d v %b exp 0 0", count, out_valid_1);
        end
        drive_pair(32'h800);
        tick();
        idle();
        checks++;
        if (count !== 4'd2 || out_pc_1 !== 32'h800) begin
            errors++;
            $display("FAIL mr_new got cnt %0d pc %h exp 2 800", count, out_pc_1);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b0;
        in_instr_1 = '0;
        in_instr_2 = '0;
        in_pc_1    = '0;
        in_pc_2    = '0;
        idle();
        test_reset_state();
        tick();
        tick();
        reset = 1'b1;
        tick();
        test_single_pair();
        test_fill();
        test_simul_and_wrap();
        test_over_dequeue();
        test_flush();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
